hwpe_stream_copy_sink: RTL and testbench

Receiving end of the HWPE stream copy network. It monitors an original stream at its consumer, `original_i`, and the matching copy stream, `copy_i`, produced upstream by a copy source with the same `COPY_TYPE`. Each cycle it checks that handshake, strobe and reduced data agree. It also checks that the copy stream holds stable while stalled. Mismatches are reported as a registered fault pulse, a cause vector, a sticky flag and a saturating error counter, all feeding the safety/fault-aggregation logic.

---
 rtl/hwpe_stream_package.sv | 65 ++++++
 rtl/hwpe_stream_intf_stream.sv | 26 ++
 rtl/hwpe_stream_copy_expect.sv | 65 ++++++
 rtl/hwpe_stream_copy_sink.sv | 157 +++++++++++++++
 tb/tb_hwpe_stream_copy_sink.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hwpe_stream_package.sv
// Shared types and constants of the HWPE stream copy network.
// hwpe_copy_t selects how much of a stream a copy carries. The helper
// functions give the copy-stream widths and the fields each depth checks.
package hwpe_stream_package;

  typedef enum logic [1:0] {
    COPY      = 2'd0,
    PARITY    = 2'd1,
    STRB_ONLY = 2'd2,
    ZERO      = 2'd3
  } hwpe_copy_t;

  // Bit positions inside the copy-checker fault cause vector
  localparam int unsigned COPY_FAULT_VALID = 0;
  localparam int unsigned COPY_FAULT_STRB  = 1;
  localparam int unsigned COPY_FAULT_DATA  = 2;
  localparam int unsigned COPY_FAULT_STAB  = 3;
  localparam int unsigned COPY_FAULT_W     = 4;

  // Data width of the copy stream for a given copy depth
  function automatic int unsigned copy_data_width(input hwpe_copy_t copy_type,
                                                  input int unsigned data_width,
                                                  input int unsigned strb_width);
    int unsigned w;
    case (copy_type)
      COPY:    w = data_width;
      PARITY:  w = strb_width;
      default: w = 1;
    endcase
    return w;
  endfunction

  // Strobe width of the copy stream for a given copy depth
  function automatic int unsigned copy_strb_width(input hwpe_copy_t copy_type,
                                                  input int unsigned strb_width);
    int unsigned w;
    case (copy_type)
      ZERO:    w = 1;
      default: w = strb_width;
    endcase
    return w;
  endfunction

  // True when the copy carries data that must be compared
  function automatic logic copy_checks_data(input hwpe_copy_t copy_type);
    logic c;
    case (copy_type)
      COPY:    c = 1'b1;
      PARITY:  c = 1'b1;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // True when the copy carries a strobe that must be compared
  function automatic logic copy_checks_strb(input hwpe_copy_t copy_type);
    logic c;
    case (copy_type)
      ZERO:    c = 1'b0;
      default: c = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle used throughout the HWPE stream network.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (
    output valid, data, strb,
    input  ready
  );

  modport sink (
    input  valid, data, strb,
    output ready
  );

  modport monitor (
    input valid, ready, data, strb
  );

endinterface

// File: rtl/hwpe_stream_copy_expect.sv
// Expected copy-stream payload for a given copy depth, derived purely
// combinationally from the original data and strobe. Shared by any checker
// that needs to know what a copy source should have produced.
module hwpe_stream_copy_expect
  import hwpe_stream_package::*;
#(
  parameter hwpe_copy_t  COPY_TYPE      = COPY,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned EXP_DATA_WIDTH = copy_data_width(COPY_TYPE, DATA_WIDTH, STRB_WIDTH),
  parameter int unsigned EXP_STRB_WIDTH = copy_strb_width(COPY_TYPE, STRB_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]     data_i,
  input  logic [STRB_WIDTH-1:0]     strb_i,
  output logic [EXP_DATA_WIDTH-1:0] data_o,
  output logic [EXP_STRB_WIDTH-1:0] strb_o
);

  localparam int unsigned LANE_WIDTH = DATA_WIDTH / STRB_WIDTH;

  // One parity bit per strobe lane
  function automatic logic [STRB_WIDTH-1:0] lane_parity(input logic [DATA_WIDTH-1:0] d);
    logic [STRB_WIDTH-1:0] p;
    p = {STRB_WIDTH{1'b0}};
    for (int i = 0; i < int'(STRB_WIDTH); i++) begin
      p[i] = ^d[i*LANE_WIDTH +: LANE_WIDTH];
    end
    return p;
  endfunction

  if ((DATA_WIDTH % STRB_WIDTH) != 0) begin : gen_bad_strb
    $fatal(1, "hwpe_stream_copy_expect: DATA_WIDTH must be a multiple of STRB_WIDTH");
  end

  case (COPY_TYPE)
    COPY: begin : gen_copy
      assign data_o = data_i;
      assign strb_o = strb_i;
    end
    PARITY: begin : gen_parity
      assign data_o = lane_parity(data_i);
      assign strb_o = strb_i;
    end
    STRB_ONLY: begin : gen_strb_only
      logic unused_data_s;
      assign unused_data_s = ^data_i;
      assign data_o        = 1'b0;
      assign strb_o        = strb_i;
    end
    ZERO: begin : gen_zero
      logic unused_data_s;
      assign unused_data_s = ^{data_i, strb_i};
      assign data_o        = 1'b0;
      assign strb_o        = 1'b0;
    end
    default: begin : gen_bad_type
      logic unused_data_s;
      assign unused_data_s = ^{data_i, strb_i};
      assign data_o        = {EXP_DATA_WIDTH{1'b0}};
      assign strb_o        = {EXP_STRB_WIDTH{1'b0}};
      $fatal(1, "hwpe_stream_copy_expect: unsupported COPY_TYPE");
    end
  endcase

endmodule

// File: rtl/hwpe_stream_copy_sink.sv
// Receiving end of a stream copy pair. Watches the original stream at its
// consumer and the redundant copy, flags any disagreement in handshake,
// strobe or reduced data, and flags a copy that changes while stalled.
// Faults are reported as a one-cycle-late pulse with cause bits, a sticky
// flag and a saturating cycle counter.
module hwpe_stream_copy_sink
  import hwpe_stream_package::*;
#(
  parameter hwpe_copy_t  COPY_TYPE  = COPY,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  hwpe_stream_intf_stream.monitor original_i,
  hwpe_stream_intf_stream.sink    copy_i,
  output logic                    fault_o,
  output logic [COPY_FAULT_W-1:0] fault_cause_o,
  output logic                    fault_sticky_o,
  output logic [CNT_WIDTH-1:0]    fault_cnt_o
);

  localparam int unsigned CDW = copy_data_width(COPY_TYPE, DATA_WIDTH, STRB_WIDTH);
  localparam int unsigned CSW = copy_strb_width(COPY_TYPE, STRB_WIDTH);

  // Constant per instance: which copy fields carry information
  localparam logic CHECK_DATA = copy_checks_data(COPY_TYPE);
  localparam logic CHECK_STRB = copy_checks_strb(COPY_TYPE);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic                    orig_valid_s;
  logic                    copy_valid_s;
  logic                    copy_ready_s;
  logic                    both_valid_s;
  logic [CDW-1:0]          copy_data_s;
  logic [CSW-1:0]          copy_strb_s;
  logic [CDW-1:0]          exp_data_s;
  logic [CSW-1:0]          exp_strb_s;
  logic                    data_diff_s;
  logic                    strb_diff_s;
  logic                    hold_data_diff_s;
  logic                    hold_strb_diff_s;
  logic [COPY_FAULT_W-1:0] cause_s;
  logic                    mismatch_s;

  logic                    stall_r;
  logic [CDW-1:0]          hold_data_r;
  logic [CSW-1:0]          hold_strb_r;
  logic                    fault_r;
  logic [COPY_FAULT_W-1:0] fault_cause_r;
  logic                    sticky_r;
  logic [CNT_WIDTH-1:0]    cnt_r;

  // The copy network sees exactly the backpressure of the original consumer
  assign copy_i.ready = original_i.ready;
  assign copy_ready_s = original_i.ready;

  assign orig_valid_s = original_i.valid;
  assign copy_valid_s = copy_i.valid;
  assign copy_data_s  = copy_i.data;
  assign copy_strb_s  = copy_i.strb;
  assign both_valid_s = orig_valid_s & copy_valid_s;

  hwpe_stream_copy_expect #(
    .COPY_TYPE      ( COPY_TYPE  ),
    .DATA_WIDTH     ( DATA_WIDTH ),
    .STRB_WIDTH     ( STRB_WIDTH ),
    .EXP_DATA_WIDTH ( CDW        ),
    .EXP_STRB_WIDTH ( CSW        )
  ) i_expect (
    .data_i ( original_i.data ),
    .strb_i ( original_i.strb ),
    .data_o ( exp_data_s      ),
    .strb_o ( exp_strb_s      )
  );

  // Raw field comparisons against the expectation and the held values
  always_comb begin
    data_diff_s      = (copy_data_s != exp_data_s);
    strb_diff_s      = (copy_strb_s != exp_strb_s);
    hold_data_diff_s = (copy_data_s != hold_data_r);
    hold_strb_diff_s = (copy_strb_s != hold_strb_r);
  end

  // Per-cycle fault causes; fields a copy depth does not carry are masked
  always_comb begin
    cause_s                   = {COPY_FAULT_W{1'b0}};
    cause_s[COPY_FAULT_VALID] = orig_valid_s ^ copy_valid_s;
    cause_s[COPY_FAULT_STRB]  = CHECK_STRB & both_valid_s & strb_diff_s;
    cause_s[COPY_FAULT_DATA]  = CHECK_DATA & both_valid_s & data_diff_s;
    cause_s[COPY_FAULT_STAB]  = stall_r & (~copy_valid_s
                                           | (CHECK_DATA & hold_data_diff_s)
                                           | (CHECK_STRB & hold_strb_diff_s));
    mismatch_s                = |cause_s;
  end

  // Stall flag and copy payload snapshot, taken every cycle for the stability check
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_r     <= 1'b0;
      hold_data_r <= {CDW{1'b0}};
      hold_strb_r <= {CSW{1'b0}};
    end else begin
      stall_r     <= copy_valid_s & ~copy_ready_s;
      hold_data_r <= copy_data_s;
      hold_strb_r <= copy_strb_s;
    end
  end

  // Fault pulse and its cause, one cycle after the mismatch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_r       <= 1'b0;
      fault_cause_r <= {COPY_FAULT_W{1'b0}};
    end else begin
      fault_r       <= mismatch_s;
      fault_cause_r <= cause_s;
    end
  end

  // Sticky flag; a mismatch wins over a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_r <= 1'b0;
    end else if (mismatch_s) begin
      sticky_r <= 1'b1;
    end else if (clear_i) begin
      sticky_r <= 1'b0;
    end else begin
      sticky_r <= sticky_r;
    end
  end

  // Saturating fault-cycle counter; a clear still counts a coincident mismatch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= CNT_ZERO;
    end else if (clear_i) begin
      cnt_r <= mismatch_s ? CNT_ONE : CNT_ZERO;
    end else if (mismatch_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign fault_o        = fault_r;
  assign fault_cause_o  = fault_cause_r;
  assign fault_sticky_o = sticky_r;
  assign fault_cnt_o    = cnt_r;

endmodule

// File: tb/tb_hwpe_stream_copy_sink.sv
// Bench for hwpe_stream_copy_sink. Four sinks share one original stream:
// dut0 COPY, dut1 PARITY, dut2 STRB_ONLY, dut3 COPY with a 2-bit counter.
module tb_hwpe_stream_copy_sink;
  import hwpe_stream_package::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(4)) orig_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(4)) cp0 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(4),  .STRB_WIDTH(4)) cp1 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(1),  .STRB_WIDTH(4)) cp2 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32), .STRB_WIDTH(4)) cp3 ();

  logic       flt [4];
  logic [3:0] cause [4];
  logic       stk [4];
  logic [7:0] cnt0, cnt1, cnt2;
  logic [1:0] cnt3;

  hwpe_stream_copy_sink #(.COPY_TYPE(COPY), .DATA_WIDTH(32), .STRB_WIDTH(4), .CNT_WIDTH(8)) u_copy (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .original_i(orig_if), .copy_i(cp0),
    .fault_o(flt[0]), .fault_cause_o(cause[0]), .fault_sticky_o(stk[0]), .fault_cnt_o(cnt0));
  hwpe_stream_copy_sink #(.COPY_TYPE(PARITY), .DATA_WIDTH(32), .STRB_WIDTH(4), .CNT_WIDTH(8)) u_par (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .original_i(orig_if), .copy_i(cp1),
    .fault_o(flt[1]), .fault_cause_o(cause[1]), .fault_sticky_o(stk[1]), .fault_cnt_o(cnt1));
  hwpe_stream_copy_sink #(.COPY_TYPE(STRB_ONLY), .DATA_WIDTH(32), .STRB_WIDTH(4), .CNT_WIDTH(8)) u_strb (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .original_i(orig_if), .copy_i(cp2),
    .fault_o(flt[2]), .fault_cause_o(cause[2]), .fault_sticky_o(stk[2]), .fault_cnt_o(cnt2));
  hwpe_stream_copy_sink #(.COPY_TYPE(COPY), .DATA_WIDTH(32), .STRB_WIDTH(4), .CNT_WIDTH(2)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .original_i(orig_if), .copy_i(cp3),
    .fault_o(flt[3]), .fault_cause_o(cause[3]), .fault_sticky_o(stk[3]), .fault_cnt_o(cnt3));

  // Stimulus state
  logic        ov, orr;
  logic [31:0] od;
  logic [3:0]  os;
  logic        cv [4];
  logic [31:0] cd [4];
  logic [3:0]  cs [4];

  // Reference model state
  logic        pstall [4];
  logic [31:0] pcd [4];
  logic [3:0]  pcs [4];
  logic [3:0]  exp_cause [4];
  logic        exp_fault [4];
  logic        exp_sticky [4];
  int          exp_cnt [4];

  function automatic int cnt_o(input int k);
    case (k)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  function automatic int cnt_max(input int k);
    return (k == 3) ? 3 : 255;
  endfunction

  function automatic int dwidth(input int k);
    case (k)
      1: return 4;
      2: return 1;
      default: return 32;
    endcase
  endfunction

  function automatic logic checks_data(input int k);
    return (k != 2);
  endfunction

  // What a correct copy source would send for this original word
  function automatic logic [31:0] ref_expect(input int k, input logic [31:0] d);
    logic [31:0] r;
    r = 32'd0;
    if (k == 1) begin
      for (int b = 0; b < 4; b++) r[b] = ^d[8*b +: 8];
    end else if (k != 2) begin
      r = d;
    end
    return r;
  endfunction

  task automatic set_match();
    for (int k = 0; k < 4; k++) begin
      cv[k] = ov;
      cs[k] = os;
      cd[k] = ref_expect(k, od);
    end
  endtask

  task automatic drive();
    orig_if.valid = ov; orig_if.ready = orr; orig_if.data = od; orig_if.strb = os;
    cp0.valid = cv[0]; cp0.data = cd[0];       cp0.strb = cs[0];
    cp1.valid = cv[1]; cp1.data = cd[1][3:0];  cp1.strb = cs[1];
    cp2.valid = cv[2]; cp2.data = cd[2][0:0];  cp2.strb = cs[2];
    cp3.valid = cv[3]; cp3.data = cd[3];       cp3.strb = cs[3];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      pstall[k] = 1'b0; pcd[k] = 32'd0; pcs[k] = 4'd0;
      exp_cause[k] = 4'd0; exp_fault[k] = 1'b0; exp_sticky[k] = 1'b0; exp_cnt[k] = 0;
    end
  endtask

  // Drive one cycle, predict the outcome from the stream rules, then clock
  task automatic cycle();
    logic [3:0] c [4];
    drive();
    for (int k = 0; k < 4; k++) begin
      logic both;
      logic stab;
      both = ov & cv[k];
      stab = pstall[k] & (~cv[k] | (checks_data(k) & (cd[k] != pcd[k])) | (cs[k] != pcs[k]));
      c[k] = {stab, both & checks_data(k) & (cd[k] != ref_expect(k, od)),
              both & (cs[k] != os), ov ^ cv[k]};
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      exp_cause[k]  = c[k];
      exp_fault[k]  = |c[k];
      exp_sticky[k] = exp_fault[k] | (exp_sticky[k] & ~clr);
      if (clr) exp_cnt[k] = exp_fault[k] ? 1 : 0;
      else if (exp_fault[k] && exp_cnt[k] < cnt_max(k)) exp_cnt[k] = exp_cnt[k] + 1;
      pstall[k] = cv[k] & ~orr;
      pcd[k] = cd[k];
      pcs[k] = cs[k];
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; clr = 1'b0; ov = 1'b0; orr = 1'b0; od = 32'd0; os = 4'd0;
    set_match();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Original stream generator that holds its word while stalled
  task automatic next_orig();
    if (!(ov && !orr)) begin
      ov = 1'($urandom_range(1)); od = $urandom; os = 4'($urandom_range(15));
    end
    orr = 1'($urandom_range(1));
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({flt[k], cause[k], stk[k]} !== 6'd0 || cnt_o(k) !== 0) begin
        fails++;
        $display("FAIL reset dut%0d: got f=%b c=%b s=%b n=%0d, expected all 0", k, flt[k], cause[k], stk[k], cnt_o(k));
      end
    end
    for (int r = 0; r < 2; r++) begin
      orr = 1'(r); drive(); #1;
      tests++;
      if ({cp0.ready, cp1.ready, cp2.ready, cp3.ready} !== {4{orr}}) begin
        fails++;
        $display("FAIL copy_ready: got %b expected %b", {cp0.ready, cp1.ready, cp2.ready, cp3.ready}, {4{orr}});
      end
    end
  endtask

  task automatic test_copy_random();
    apply_reset();
    for (int n = 0; n < 1000; n++) begin
      next_orig(); set_match(); cycle();
      tests++;
      if (flt[0] !== 1'b0 || flt[0] !== exp_fault[0]) begin
        fails++;
        $display("FAIL copy_clean cycle %0d: got fault %b expected 0", n, flt[0]);
      end
    end
    tests++;
    if (cnt_o(0) !== 0 || stk[0] !== 1'b0) begin
      fails++;
      $display("FAIL copy_clean_cnt: got cnt %0d sticky %b expected 0 0", cnt_o(0), stk[0]);
    end
  endtask

  task automatic test_random_faults();
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      next_orig(); set_match();
      clr = ($urandom_range(31) == 0);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(7) == 0) begin
          case ($urandom_range(2))
            0: cv[k] = ~cv[k];
            1: cs[k][$urandom_range(3)] ^= 1'b1;
            default: cd[k][$urandom_range(dwidth(k) - 1)] ^= 1'b1;
          endcase
        end
      end
      cycle();
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (flt[k] !== exp_fault[k] || cause[k] !== exp_cause[k] || stk[k] !== exp_sticky[k] || cnt_o(k) !== exp_cnt[k]) begin
          fails++;
          $display("FAIL rand_model dut%0d cycle %0d: got f=%b c=%b s=%b n=%0d expected f=%b c=%b s=%b n=%0d",
                   k, n, flt[k], cause[k], stk[k], cnt_o(k), exp_fault[k], exp_cause[k], exp_sticky[k], exp_cnt[k]);
        end
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_parity();
    apply_reset();
    ov = 1'b1; orr = 1'b1; od = 32'h0000_0001; os = 4'hF;
    set_match(); cd[1] = 32'd0;
    cycle();
    tests++;
    if (flt[1] !== 1'b1 || cause[1] !== 4'b0100 || cnt1 !== 8'd1 || stk[1] !== 1'b1) begin
      fails++;
      $display("FAIL parity: got f=%b c=%b n=%0d s=%b expected 1 0100 1 1", flt[1], cause[1], cnt1, stk[1]);
    end
    ov = 1'b0; set_match(); cycle();
    tests++;
    if (flt[1] !== 1'b0 || cnt1 !== 8'd1) begin
      fails++;
      $display("FAIL parity_pulse: got f=%b n=%0d expected 0 1", flt[1], cnt1);
    end
  endtask

  task automatic test_strb_lag();
    apply_reset();
    orr = 1'b1; od = $urandom; os = 4'($urandom_range(15));
    ov = 1'b1; set_match(); cv[2] = 1'b0; cycle();
    tests++;
    if (flt[2] !== 1'b1 || cause[2] !== 4'b0001) begin
      fails++;
      $display("FAIL strb_lag_1: got f=%b c=%b expected 1 0001", flt[2], cause[2]);
    end
    ov = 1'b0; set_match(); cv[2] = 1'b1; cycle();
    tests++;
    if (cause[2] !== 4'b0001 || cnt2 !== 8'd2 || stk[2] !== 1'b1) begin
      fails++;
      $display("FAIL strb_lag_2: got c=%b n=%0d s=%b expected 0001 2 1", cause[2], cnt2, stk[2]);
    end
    set_match(); cycle();
    tests++;
    if (flt[2] !== 1'b0 || cnt2 !== 8'd2 || stk[2] !== 1'b1) begin
      fails++;
      $display("FAIL strb_lag_3: got f=%b n=%0d s=%b expected 0 2 1", flt[2], cnt2, stk[2]);
    end
  endtask

  task automatic test_stab();
    apply_reset();
    ov = 1'b1; orr = 1'b0; od = $urandom; os = 4'hF;
    set_match(); cycle();
    tests++;
    if (flt[0] !== 1'b0) begin
      fails++;
      $display("FAIL stab_hold: got f=%b expected 0", flt[0]);
    end
    cs[0] = 4'h7; cycle();
    tests++;
    if (flt[0] !== 1'b1 || cause[0] !== 4'b1010 || flt[1] !== 1'b0 || flt[3] !== 1'b0) begin
      fails++;
      $display("FAIL stab_change: got f=%b c=%b others %b%b expected 1 1010 00", flt[0], cause[0], flt[1], flt[3]);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    orr = 1'b1; ov = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      od = $urandom; os = 4'($urandom_range(15));
      set_match(); cd[3] = od ^ 32'h0000_0100;
      cycle();
      tests++;
      if (int'(cnt3) !== ((i < 3) ? i : 3) || cause[3] !== 4'b0100) begin
        fails++;
        $display("FAIL sat_cnt step %0d: got n=%0d c=%b expected %0d 0100", i, cnt3, cause[3], (i < 3) ? i : 3);
      end
    end
    clr = 1'b1; set_match(); cycle();
    tests++;
    if (cnt3 !== 2'd0 || stk[3] !== 1'b0 || flt[3] !== 1'b0) begin
      fails++;
      $display("FAIL sat_clear: got n=%0d s=%b f=%b expected 0 0 0", cnt3, stk[3], flt[3]);
    end
    cd[3] = od ^ 32'h8000_0000; cycle();
    tests++;
    if (cnt3 !== 2'd1 || stk[3] !== 1'b1 || cause[3] !== 4'b0100) begin
      fails++;
      $display("FAIL sat_clear_hit: got n=%0d s=%b c=%b expected 1 1 0100", cnt3, stk[3], cause[3]);
    end
    clr = 1'b0;
  endtask

  task automatic test_reset_stall();
    apply_reset();
    ov = 1'b1; orr = 1'b1; od = $urandom; os = 4'hA;
    set_match(); for (int k = 0; k < 4; k++) cv[k] = 1'b0;
    cycle();
    orr = 1'b0; set_match(); cycle();
    rst_n = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (stk[k] !== 1'b0 || flt[k] !== 1'b0 || cnt_o(k) !== 0) begin
        fails++;
        $display("FAIL async_reset dut%0d: got s=%b f=%b n=%0d expected 0 0 0", k, stk[k], flt[k], cnt_o(k));
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; model_reset();
    od = ~od; os = 4'h5; set_match(); cycle();
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({flt[k], cause[k], stk[k]} !== 6'd0 || cnt_o(k) !== 0) begin
        fails++;
        $display("FAIL reset_stall dut%0d: got f=%b c=%b s=%b n=%0d expected all 0", k, flt[k], cause[k], stk[k], cnt_o(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ov = 1'b1; orr = 1'b0; od = $urandom; os = 4'hC; set_match(); cycle();
    orr = 1'b1; cycle();
    orr = 1'b0; od = ~od; os = 4'h3; set_match(); cycle();
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (flt[k] !== 1'b0) begin
        fails++;
        $display("FAIL b2b_new_word dut%0d: got f=%b expected 0", k, flt[k]);
      end
    end
    cv[0] = 1'b0; cycle();
    tests++;
    if (cause[0] !== 4'b1001 || cnt0 !== 8'd1) begin
      fails++;
      $display("FAIL b2b_drop_valid: got c=%b n=%0d expected 1001 1", cause[0], cnt0);
    end
  endtask

  initial begin
    test_reset();
    test_copy_random();
    test_parity();
    test_strb_lag();
    test_stab();
    test_saturation();
    test_reset_stall();
    test_back_to_back();
    test_random_faults();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
